// File: rtl/sfifo_param.sv
// Single-clock parametrised FIFO with inferred simple dual-port RAM (registered read),
// selectable show-ahead or normal read mode, used-word count, and sticky error flags.
module sfifo_param #(
    parameter int ShowHead    = 1,
    parameter int DataWidth   = 8,
    parameter int DataDepth   = 16,
    parameter int RAMAddWidth = 4,
    parameter int ALFull      = 1,
    parameter int ALEmpty     = 2
) (
    input  logic                   clk,
    input  logic                   sclr,
    input  logic [DataWidth-1:0]   data,
    input  logic                   wrreq,
    input  logic                   rdreq,
    input  logic                   err_clr,
    output logic [DataWidth-1:0]   q,
    output logic                   full,
    output logic                   almfull,
    output logic                   empty,
    output logic                   almempty,
    output logic [RAMAddWidth:0]   usedw,
    output logic                   overflow,
    output logic                   underflow
);
    localparam int CW = RAMAddWidth + 1;
    localparam logic [CW-1:0]          DEPTH_C = CW'(DataDepth);
    localparam logic [CW-1:0]          AF_THR  = CW'(DataDepth - ALFull);
    localparam logic [CW-1:0]          AE_THR  = CW'(ALEmpty);
    localparam logic [RAMAddWidth-1:0] PTR_ONE = RAMAddWidth'(1);

    logic [DataWidth-1:0]   r_mem [DataDepth];
    logic [DataWidth-1:0]   r_ram_q;
    logic [RAMAddWidth-1:0] r_wr_ptr;
    logic [RAMAddWidth-1:0] r_rd_ptr;
    logic [CW-1:0]          r_usedw;
    logic [CW-1:0]          w_usedw_next;
    logic                   r_full;
    logic                   r_almfull;
    logic                   r_empty;
    logic                   r_almempty;
    logic                   r_overflow;
    logic                   r_underflow;
    logic                   w_wr_acc;
    logic                   w_rd_acc;
    logic                   w_ram_re;
    logic                   w_empty_next;

    // Requests during the reset cycle are ignored entirely.
    assign w_wr_acc     = wrreq & ~r_full & ~sclr;
    assign w_rd_acc     = rdreq & ~r_empty & ~sclr;
    assign w_usedw_next = r_usedw + CW'(w_wr_acc) - CW'(w_rd_acc);

    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            r_mem[r_wr_ptr] <= data;
        end
    end

    always_ff @(posedge clk) begin
        if (sclr) begin
            r_ram_q <= '0;
        end else if (w_ram_re) begin
            r_ram_q <= r_mem[r_rd_ptr];
        end
    end

    always_ff @(posedge clk) begin
        if (sclr) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_usedw     <= '0;
            r_full      <= 1'b0;
            r_almfull   <= 1'b0;
            r_empty     <= 1'b1;
            r_almempty  <= 1'b1;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_ram_re) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            r_usedw     <= w_usedw_next;
            r_full      <= (w_usedw_next == DEPTH_C);
            r_almfull   <= (w_usedw_next >= AF_THR);
            r_almempty  <= (w_usedw_next <= AE_THR);
            r_empty     <= w_empty_next;
            // A new error wins over a simultaneous clear.
            r_overflow  <= (wrreq & r_full) | (r_overflow & ~err_clr);
            r_underflow <= (rdreq & r_empty) | (r_underflow & ~err_clr);
        end
    end

    generate
        if (ShowHead != 0) begin : g_show_ahead
            // The RAM output register is the head stage; r_empty doubles as ~stage_valid.
            logic          w_stage_valid;
            logic [CW-1:0] w_ram_cnt;

            assign w_stage_valid = ~r_empty;
            assign w_ram_cnt     = r_usedw - CW'(w_stage_valid);
            assign w_ram_re      = (w_ram_cnt != '0) & (r_empty | w_rd_acc) & ~sclr;
            assign w_empty_next  = ~(w_ram_re | (w_stage_valid & ~w_rd_acc));
            assign q             = r_ram_q;
        end else begin : g_normal
            logic                 r_rd_pend;
            logic [DataWidth-1:0] r_q;

            assign w_ram_re     = w_rd_acc;
            assign w_empty_next = (w_usedw_next == '0);
            assign q            = r_q;

            always_ff @(posedge clk) begin
                if (sclr) begin
                    r_rd_pend <= 1'b0;
                    r_q       <= '0;
                end else begin
                    r_rd_pend <= w_rd_acc;
                    if (r_rd_pend) begin
                        r_q <= r_ram_q;
                    end
                end
            end
        end
    endgenerate

    assign full      = r_full;
    assign almfull   = r_almfull;
    assign empty     = r_empty;
    assign almempty  = r_almempty;
    assign usedw     = r_usedw;
    assign overflow  = r_overflow;
    assign underflow = r_underflow;

endmodule
